window_sched: RTL and testbench
===============================

WINDOW_SCHED -- requirements
Module: window_sched

Interface
REQ-001 The block SHALL have parameter LineWidth, default 640: pixels per row.
REQ-002 The block SHALL have parameter FrameHeight, default 480: rows per frame.
REQ-003 The block SHALL have parameter KernelWidth, default 3: square window size, 2..LineWidth.
REQ-004 The block SHALL have localparams ColWidth = $clog2(LineWidth) and RowWidth = $clog2(FrameHeight).
REQ-005 The block SHALL have the following ports, one per line (name, direction, width, meaning):
  clk_i  in  1  single clock
  rst_i  in  1  synchronous, active-high reset
  start_i  in  1  arm one frame
  cont_i  in  1  re-arm automatically at end of frame
  abort_i  in  1  terminate the current frame
  in_valid_i  in  1  upstream pixel valid
  in_ready_o  out  1  upstream ready
  buf_valid_o  out  1  beat valid toward the line-buffer chain
  buf_ready_i  in  1  line-buffer chain ready
  win_valid_o  out  1  a complete KernelWidth x KernelWidth window exists on this beat
  win_row_o  out  RowWidth  window top-left row
  win_col_o  out  ColWidth  window top-left column
  sof_o  out  1  first beat of a frame
  eol_o  out  1  last beat of a row
  eof_o  out  1  last beat of a frame
  busy_o  out  1  frame in progress
  done_o  out  1  one-cycle pulse at frame completion

Function
REQ-006 The state machine SHALL have states IDLE, PRIME and STREAM.
REQ-007 fire = buf_valid_o & buf_ready_i.
REQ-008 IDLE: in_ready_o=0, buf_valid_o=0, busy_o=0; start_i moves to PRIME next cycle.
REQ-009 PRIME/STREAM: buf_valid_o=in_valid_i and in_ready_o=buf_ready_i, combinationally with zero latency; busy_o=1.
REQ-010 Counters col (0..LineWidth-1) and row (0..FrameHeight-1) SHALL advance only on fire; col wraps to 0 and row increments on col==LineWidth-1.
REQ-011 PRIME SHALL move to STREAM on the fire with row==KernelWidth-2 and col==LineWidth-1.
REQ-012 win_valid_o SHALL equal fire & (row>=KernelWidth-1) & (col>=KernelWidth-1), same cycle.
REQ-013 When win_valid_o=1: win_row_o=row-(KernelWidth-1) and win_col_o=col-(KernelWidth-1); otherwise both SHALL be 0.
REQ-014 sof_o, eol_o and eof_o SHALL be asserted only on fire, at (0,0), at col==LineWidth-1, and at (FrameHeight-1, LineWidth-1) respectively.
REQ-015 On the eof fire, counters SHALL clear and done_o SHALL pulse for the following cycle; next state SHALL be PRIME if cont_i=1 in the eof cycle, else IDLE.
REQ-016 start_i outside IDLE SHALL be ignored.
REQ-017 abort_i SHALL take priority over fire: next cycle IDLE, counters 0, no done_o; a beat in the abort cycle is still transferred but not counted.
REQ-018 Counters and outputs SHALL hold while buf_ready_i=0 or in_valid_i=0.

Reset
REQ-019 rst_i SHALL force state IDLE, counters 0, and every registered output (done_o) to 0; all combinational outputs SHALL then read 0.
REQ-020 Reset mid-frame SHALL discard frame progress with no done_o pulse.

Structure
REQ-021 The state enum typedef (IDLE/PRIME/STREAM) SHALL live in the shared vision package, vision_pkg.
REQ-022 The column counter SHALL be an instance of counter_roll with max_val_i=LineWidth-1; the row counter SHALL be local logic.

Verification (LineWidth=4, FrameHeight=3, KernelWidth=3)
REQ-023 Reset: after reset, in_ready_o=buf_valid_o=win_valid_o=busy_o=done_o=0, win_row_o=win_col_o=0.
REQ-024 Start, then 12 back-to-back beats: win_valid_o only on beats 10 and 11 with (win_row,win_col)=(0,0),(0,1); eol_o on beats 3,7,11; eof_o on beat 11; done_o in the next cycle; state IDLE.
REQ-025 buf_ready_i=0 for 3 cycles at beat 5: in_ready_o=0, counters hold at (1,1), no beat lost or duplicated.
REQ-026 abort_i at beat 5: next cycle IDLE, busy_o=0, no done_o, and the next start counts from (0,0).
REQ-027 cont_i=1 at eof: no IDLE cycle, and the next fire raises sof_o at (0,0).
REQ-028 start_i pulsed during STREAM: no effect on counters or state.

Source files
------------

// File: rtl/vision_pkg.sv
// Shared types for the vision pipeline blocks.
package vision_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } sched_state_e;

endpackage

// File: rtl/counter_roll.sv
// Rolling up-counter: counts 0..max_val_i on en_i, then wraps to 0.
module counter_roll #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] max_val_i,
  output logic [Width-1:0] count_o,
  output logic             last_o
);

  logic [Width-1:0] r_count;

  assign last_o  = (r_count == max_val_i);
  assign count_o = r_count;

  // Clear wins over enable so a frame-end or abort beat lands on zero.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_count <= '0;
    end else if (en_i) begin
      r_count <= last_o ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/window_sched.sv
// Raster scheduler for a KernelWidth x KernelWidth sliding window over a frame,
// tracking pixel position and flagging beats where a full window is available.
import vision_pkg::*;

module window_sched #(
  parameter int LineWidth   = 640,
  parameter int FrameHeight = 480,
  parameter int KernelWidth = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             cont_i,
  input  logic                             abort_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  output logic                             buf_valid_o,
  input  logic                             buf_ready_i,
  output logic                             win_valid_o,
  output logic [$clog2(FrameHeight)-1:0]   win_row_o,
  output logic [$clog2(LineWidth)-1:0]     win_col_o,
  output logic                             sof_o,
  output logic                             eol_o,
  output logic                             eof_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int ColWidth = $clog2(LineWidth);
  localparam int RowWidth = $clog2(FrameHeight);

  localparam logic [ColWidth-1:0] ColLast      = ColWidth'(LineWidth - 1);
  localparam logic [RowWidth-1:0] RowLast      = RowWidth'(FrameHeight - 1);
  localparam logic [RowWidth-1:0] RowPrimeLast = RowWidth'(KernelWidth - 2);
  localparam logic [RowWidth-1:0] RowOffset    = RowWidth'(KernelWidth - 1);
  localparam logic [ColWidth-1:0] ColOffset    = ColWidth'(KernelWidth - 1);

  sched_state_e r_state;
  sched_state_e w_state_nxt;

  logic [RowWidth-1:0] r_row;
  logic                r_done;
  logic [ColWidth-1:0] w_col;
  logic                w_col_last;
  logic                w_row_last;
  logic                w_active;
  logic                w_fire;
  logic                w_count;
  logic                w_frame_end;
  logic                w_clear;
  logic                w_win;

  assign w_active    = (r_state != IDLE);
  assign buf_valid_o = w_active & in_valid_i;
  assign in_ready_o  = w_active & buf_ready_i;
  assign busy_o      = w_active;
  assign w_fire      = buf_valid_o & buf_ready_i;

  // An abort beat still moves data but must not advance the raster position.
  assign w_count     = w_fire & ~abort_i;
  assign w_row_last  = (r_row == RowLast);
  assign w_frame_end = w_count & w_row_last & w_col_last;
  assign w_clear     = (w_active & abort_i) | w_frame_end;

  counter_roll #(
    .Width (ColWidth)
  ) u_col (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (w_clear),
    .en_i      (w_count),
    .max_val_i (ColLast),
    .count_o   (w_col),
    .last_o    (w_col_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || w_clear) begin
      r_row <= '0;
    end else if (w_count && w_col_last) begin
      r_row <= r_row + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_frame_end;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PRIME covers the rows that only fill the line buffers; frame end is
  // checked first so frames shorter than the kernel still terminate.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) w_state_nxt = PRIME;
      end
      PRIME: begin
        if (abort_i) begin
          w_state_nxt = IDLE;
        end else if (w_frame_end) begin
          w_state_nxt = cont_i ? PRIME : IDLE;
        end else if (w_count && (r_row == RowPrimeLast) && w_col_last) begin
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (abort_i) begin
          w_state_nxt = IDLE;
        end else if (w_frame_end) begin
          w_state_nxt = cont_i ? PRIME : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_win       = w_fire & (r_row >= RowOffset) & (w_col >= ColOffset);
  assign win_valid_o = w_win;
  assign win_row_o   = w_win ? (r_row - RowOffset) : '0;
  assign win_col_o   = w_win ? (w_col - ColOffset) : '0;

  assign sof_o  = w_fire & (r_row == '0) & (w_col == '0);
  assign eol_o  = w_fire & w_col_last;
  assign eof_o  = w_fire & w_row_last & w_col_last;
  assign done_o = r_done;

endmodule

// File: tb/tb_window_sched.sv
// Scoreboard bench for window_sched on a 4x3 frame with a 3x3 kernel.
module tb_window_sched;

  localparam int LW = 4;
  localparam int FH = 3;
  localparam int K  = 3;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       cont_i;
  logic       abort_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic       buf_valid_o;
  logic       buf_ready_i;
  logic       win_valid_o;
  logic [1:0] win_row_o;
  logic [1:0] win_col_o;
  logic       sof_o;
  logic       eol_o;
  logic       eof_o;
  logic       busy_o;
  logic       done_o;

  int total = 0;
  int bad   = 0;

  int mState = 0;
  int mRow   = 0;
  int mCol   = 0;
  int mDone  = 0;

  logic [7:0] expQ[$];
  logic [7:0] monExp;

  window_sched #(
    .LineWidth   (LW),
    .FrameHeight (FH),
    .KernelWidth (K)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .cont_i      (cont_i),
    .abort_i     (abort_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .buf_valid_o (buf_valid_o),
    .buf_ready_i (buf_ready_i),
    .win_valid_o (win_valid_o),
    .win_row_o   (win_row_o),
    .win_col_o   (win_col_o),
    .sof_o       (sof_o),
    .eol_o       (eol_o),
    .eof_o       (eof_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Packed beat expectation: {sof, eol, eof, win_valid, win_row, win_col}.
  function automatic logic [7:0] expBeat(input int r, input int c);
    logic       sof, eol, eof, winv;
    logic [1:0] wr, wc;
    sof  = (r == 0) && (c == 0);
    eol  = (c == LW - 1);
    eof  = (r == FH - 1) && (c == LW - 1);
    winv = (r >= K - 1) && (c >= K - 1);
    wr   = winv ? 2'(r - (K - 1)) : 2'd0;
    wc   = winv ? 2'(c - (K - 1)) : 2'd0;
    return {sof, eol, eof, winv, wr, wc};
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i && buf_valid_o && buf_ready_i) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_beat", 32'd1, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("beat", {24'd0, sof_o, eol_o, eof_o, win_valid_o, win_row_o, win_col_o},
                    {24'd0, monExp});
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic rdy, input logic st,
                               input logic cn, input logic ab);
    logic expFire;
    int   nextDone;
    in_valid_i  = v;
    buf_ready_i = rdy;
    start_i     = st;
    cont_i      = cn;
    abort_i     = ab;
    expFire = (mState != 0) && v && rdy;
    if (expFire) expQ.push_back(expBeat(mRow, mCol));
    @(negedge clk_i);
    checkOutput("busy", {31'd0, busy_o}, {31'd0, mState != 0});
    checkOutput("in_ready", {31'd0, in_ready_o}, {31'd0, (mState != 0) && rdy});
    checkOutput("buf_valid", {31'd0, buf_valid_o}, {31'd0, (mState != 0) && v});
    checkOutput("done", {31'd0, done_o}, mDone);
    if (!expFire) begin
      checkOutput("quiet", {24'd0, sof_o, eol_o, eof_o, win_valid_o, win_row_o, win_col_o}, 32'd0);
    end
    nextDone = 0;
    if (mState == 0) begin
      if (st) mState = 1;
    end else if (ab) begin
      mState = 0;
      mRow   = 0;
      mCol   = 0;
    end else if (expFire) begin
      if (mRow == FH - 1 && mCol == LW - 1) begin
        mRow     = 0;
        mCol     = 0;
        nextDone = 1;
        mState   = cn ? 1 : 0;
      end else if (mCol == LW - 1) begin
        if (mState == 1 && mRow == K - 2) mState = 2;
        mCol = 0;
        mRow++;
      end else begin
        mCol++;
      end
    end
    mDone = nextDone;
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyReset();
    rst_i       = 1'b1;
    in_valid_i  = 1'b1;
    buf_ready_i = 1'b1;
    start_i     = 1'b1;
    cont_i      = 1'b0;
    abort_i     = 1'b0;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    checkOutput("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
    checkOutput("rst_buf_valid", {31'd0, buf_valid_o}, 32'd0);
    checkOutput("rst_win_valid", {31'd0, win_valid_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    checkOutput("rst_win_pos", {28'd0, win_row_o, win_col_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    start_i = 1'b0;
    mState  = 0;
    mRow    = 0;
    mCol    = 0;
    mDone   = 0;
  endtask

  task automatic runBeats(input int n, input logic cn);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, cn, 1'b0);
  endtask

  initial begin
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Single frame, back to back, then done pulse and idle.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runBeats(12, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure at beat 5 for three cycles.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runBeats(5, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runBeats(7, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort at beat 5, then a fresh frame from (0,0).
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runBeats(5, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runBeats(12, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Continuous mode: second frame follows with no idle cycle.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runBeats(12, 1'b1);
    runBeats(12, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // start pulses during STREAM are ignored.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runBeats(8, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    runBeats(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame discards progress without a done pulse.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runBeats(6, 1'b0);
    applyReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runBeats(12, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomised handshakes, starts, continues and rare aborts.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 47) == 0));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    checkOutput("queue_empty", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
